// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared types and default widths for the TX frame buffer read path.
// Rev 1.0
`default_nettype none

package eth_tx_pkg;

  localparam int ETH_TX_ADDR_W = 11;
  localparam int ETH_TX_LEN_W  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tx_rd_state_t;

endpackage

`default_nettype wire

// File: rtl/eth_tx_frame_reader.sv
// eth_tx_frame_reader: streams a frame from the 16-bit buffer port to the MAC, one byte per cycle.
// Rev 1.0
`default_nettype none

module eth_tx_frame_reader
  import eth_tx_pkg::*;
#(
  parameter int ADDR_W = ETH_TX_ADDR_W,
  parameter int LEN_W  = ETH_TX_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              tx_last,
  input  logic              tx_ready
);

  localparam logic [1:0]     c_idle = IDLE;
  localparam logic [1:0]     c_run  = RUN;
  localparam logic [1:0]     c_done = DONE;
  localparam logic [LEN_W:0] c_one  = (LEN_W+1)'(1);

  logic [1:0]        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [LEN_W-1:0]  r_fetch_left;
  logic [LEN_W-1:0]  r_out_cnt;
  logic              r_rd_pend;
  logic [15:0]       r_pf_data;
  logic              r_pf_valid;
  logic [7:0]        r_hi_data;
  logic              r_hi_valid;
  logic              r_hi_last;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic              r_tx_last;

  logic              w_run;
  logic              w_adv;
  logic              w_take_hi;
  logic              w_take_pf;
  logic              w_take_rd;
  logic              w_fill_pf;
  logic              w_issue;
  logic              w_last_hs;
  logic [15:0]       w_hw;
  logic [LEN_W:0]    w_idx1;
  logic [LEN_W:0]    w_len_x;
  logic [LEN_W-1:0]  w_half;

  assign w_run     = (r_state == c_run) && !abort;
  assign w_adv     = !r_tx_valid || tx_ready;
  // Byte sources in age order: pending high byte, prefetch, then data returning this cycle.
  assign w_take_hi = w_run && w_adv && r_hi_valid;
  assign w_take_pf = w_run && w_adv && !r_hi_valid && r_pf_valid;
  assign w_take_rd = w_run && w_adv && !r_hi_valid && !r_pf_valid && r_rd_pend;
  assign w_fill_pf = w_run && r_rd_pend && !w_take_rd;
  assign w_issue   = w_run && (r_fetch_left != '0) && !r_rd_pend && (!r_pf_valid || w_take_pf);
  assign w_last_hs = r_tx_valid && tx_ready && r_tx_last;
  assign w_hw      = w_take_pf ? r_pf_data : mem_rdata;

  // w_idx1 is the index of the high byte of the halfword being loaded.
  assign w_len_x   = {1'b0, r_len};
  assign w_idx1    = {1'b0, r_out_cnt} + c_one;
  assign w_half    = {1'b0, len[LEN_W-1:1]} + LEN_W'(len[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_idle;
      r_len        <= '0;
      r_fetch_addr <= '0;
      r_fetch_left <= '0;
      r_out_cnt    <= '0;
      r_rd_pend    <= 1'b0;
      r_pf_data    <= '0;
      r_pf_valid   <= 1'b0;
      r_hi_data    <= '0;
      r_hi_valid   <= 1'b0;
      r_hi_last    <= 1'b0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_last    <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_len        <= len;
            r_fetch_addr <= base_addr;
            r_fetch_left <= w_half;
            r_out_cnt    <= '0;
            r_state      <= (len == '0) ? c_done : c_run;
          end
        end
        c_run: begin
          if (abort)          r_state <= c_idle;
          else if (w_last_hs) r_state <= c_done;
        end
        default: r_state <= c_idle;
      endcase

      if (w_run) begin
        r_rd_pend <= w_issue;
        if (w_issue) begin
          r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
          r_fetch_left <= r_fetch_left - LEN_W'(1);
        end

        if (w_fill_pf) begin
          r_pf_data  <= mem_rdata;
          r_pf_valid <= 1'b1;
        end else if (w_take_pf) begin
          r_pf_valid <= 1'b0;
        end

        if (w_take_hi) begin
          r_tx_data  <= r_hi_data;
          r_tx_last  <= r_hi_last;
          r_tx_valid <= 1'b1;
          r_hi_valid <= 1'b0;
          r_out_cnt  <= r_out_cnt + LEN_W'(1);
        end else if (w_take_pf || w_take_rd) begin
          r_tx_data  <= w_hw[7:0];
          r_tx_last  <= (w_idx1 == w_len_x);
          r_tx_valid <= 1'b1;
          r_hi_data  <= w_hw[15:8];
          r_hi_valid <= (w_idx1 < w_len_x);
          r_hi_last  <= ((w_idx1 + c_one) == w_len_x);
          r_out_cnt  <= r_out_cnt + LEN_W'(1);
        end else if (w_adv) begin
          r_tx_valid <= 1'b0;
        end
      end else begin
        // Outside an active run (including abort) every in-flight byte is dropped.
        r_rd_pend  <= 1'b0;
        r_pf_valid <= 1'b0;
        r_hi_valid <= 1'b0;
        r_tx_valid <= 1'b0;
      end
    end
  end

  assign busy     = (r_state == c_run);
  assign done     = (r_state == c_done);
  assign mem_en   = w_issue;
  assign mem_addr = r_fetch_addr;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign tx_last  = r_tx_last;

endmodule

`default_nettype wire

// File: tb/tb_eth_tx_frame_reader.sv
// tb_eth_tx_frame_reader: directed table-driven bench with a buffer model and stream monitor.
// Rev 1.0
`default_nettype none

module tb_eth_tx_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] base_addr;
  logic [11:0] len;
  logic        abort;
  logic        busy;
  logic        done;
  logic        mem_en;
  logic [10:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;

  eth_tx_frame_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .abort(abort), .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:2047];
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;
  int t_start;

  logic [7:0]  got_b[$];
  logic        got_l[$];
  logic [10:0] rd_addr[$];
  int first_cyc, done_cyc, done_cnt, rd_cnt, overlap, stall_err, busy_seen;
  logic prev_en, prev_valid, prev_ready, prev_last;
  logic [7:0] prev_data;

  typedef struct {
    logic [10:0] base;
    logic [11:0] flen;
    int          mode;
    int          exp_reads;
    int          exp_done;
    int          exp_first;
  } vec_t;
  vec_t vecs[7];

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else                 tx_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      if (got_b.size() == 0) first_cyc = cyc;
      got_b.push_back(tx_data);
      got_l.push_back(tx_last);
    end
    if (mem_en) begin
      rd_cnt++;
      rd_addr.push_back(mem_addr);
      if (prev_en) overlap++;
    end
    if (prev_valid && !prev_ready && !(tx_valid && tx_data == prev_data && tx_last == prev_last))
      stall_err++;
    if (done) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt++;
    end
    if (busy) busy_seen++;
    prev_en    = mem_en;
    prev_valid = tx_valid;
    prev_ready = tx_ready;
    prev_data  = tx_data;
    prev_last  = tx_last;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [10:0] b, input int i);
    logic [10:0] a;
    logic [15:0] hw;
    a  = b + 11'(i / 2);
    hw = mem[a];
    return (i % 2 == 1) ? hw[15:8] : hw[7:0];
  endfunction

  task automatic clear_mon();
    got_b.delete(); got_l.delete(); rd_addr.delete();
    first_cyc = -1; done_cyc = -1; done_cnt = 0; rd_cnt = 0;
    overlap = 0; stall_err = 0; busy_seen = 0;
    prev_en = 1'b0; prev_valid = 1'b0; prev_ready = 1'b1;
  endtask

  task automatic do_start(input logic [10:0] b, input logic [11:0] l, input logic ab);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l; abort = ab; t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 4000 && done_cnt == 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [10:0] b, input int n,
                             input int exp_reads, input int exp_done, input int exp_first);
    int derr;
    int lerr;
    derr = 0;
    lerr = 0;
    for (int i = 0; i < got_b.size(); i++) begin
      if (got_b[i] !== exp_byte(b, i)) derr++;
      if (got_l[i] !== 1'(i == n - 1)) lerr++;
    end
    check({tag, " byte count"}, got_b.size(), n);
    check({tag, " data errors"}, derr, 0);
    check({tag, " last errors"}, lerr, 0);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " reads"}, rd_cnt, exp_reads);
    check({tag, " overlapping reads"}, overlap, 0);
    check({tag, " stall instability"}, stall_err, 0);
    if (exp_done >= 0) begin
      check({tag, " done cycle"}, done_cyc - t_start, exp_done);
      check({tag, " busy cycles"}, busy_seen, exp_done - 1);
    end
    if (exp_first >= 0) check({tag, " first byte cycle"}, first_cyc - t_start, exp_first);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; len = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'(i * 997 + 13);
    mem[5] = 16'h0100; mem[6] = 16'h0302; mem[11'h7FF] = 16'hBBAA; mem[0] = 16'hDDCC;

    vecs[0] = '{11'd5,     12'd4,  0, 2,  7,  3};
    vecs[1] = '{11'h7FF,   12'd3,  0, 2,  6,  3};
    vecs[2] = '{11'd100,   12'd64, 1, 32, -1, -1};
    vecs[3] = '{11'd0,     12'd0,  0, 0,  1,  -1};
    vecs[4] = '{11'd200,   12'd1,  0, 1,  4,  3};
    vecs[5] = '{11'd300,   12'd2,  0, 1,  5,  3};
    vecs[6] = '{11'h7FE,   12'd7,  0, 4,  10, 3};

    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset mem_en", mem_en, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset tx_data", tx_data, 0);
    check("reset tx_valid", tx_valid, 0);
    check("reset tx_last", tx_last, 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      clear_mon();
      ready_mode = vecs[v].mode;
      do_start(vecs[v].base, vecs[v].flen, 1'b0);
      wait_done();
      check_frame($sformatf("vec%0d", v), vecs[v].base, int'(vecs[v].flen),
                  vecs[v].exp_reads, vecs[v].exp_done, vecs[v].exp_first);
      if (v == 0) check("vec0 byte sequence", {got_b[0], got_b[1], got_b[2], got_b[3]}, 32'h00010203);
      if (v == 1) begin
        check("vec1 byte sequence", {got_b[0], got_b[1], got_b[2]}, 24'hAABBCC);
        check("vec1 first addr", rd_addr[0], 11'h7FF);
        check("vec1 wrapped addr", rd_addr[1], 11'h000);
      end
    end
    ready_mode = 0;

    // second start mid-frame must be ignored
    clear_mon();
    do_start(11'd400, 12'd10, 1'b0);
    for (int k = 0; k < 100 && got_b.size() < 3; k++) @(posedge clk);
    #1 start = 1'b1; base_addr = 11'd0; len = 12'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (5) @(posedge clk);
    check_frame("ignored start", 11'd400, 10, 5, 13, 3);
    check("ignored start busy after", busy, 0);

    // abort in IDLE has no effect
    clear_mon();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (3) @(posedge clk);
    check("idle abort busy", busy_seen, 0);
    check("idle abort done", done_cnt, 0);

    // start together with abort in IDLE: start wins
    clear_mon();
    do_start(11'd800, 12'd2, 1'b1);
    wait_done();
    check_frame("start+abort", 11'd800, 2, 1, 5, 3);

    // abort mid-frame
    clear_mon();
    do_start(11'd500, 12'd100, 1'b0);
    for (int k = 0; k < 200 && got_b.size() < 20; k++) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort tx_valid", tx_valid, 0);
    check("abort busy", busy, 0);
    check("abort mem_en", mem_en, 0);
    begin
      int perr;
      perr = 0;
      for (int i = 0; i < got_b.size(); i++) if (got_b[i] !== exp_byte(11'd500, i)) perr++;
      check("abort prefix errors", perr, 0);
      check("abort reached byte 20", got_b.size() >= 20, 1);
    end
    repeat (5) @(posedge clk);
    check("abort no done", done_cnt, 0);
    clear_mon();
    do_start(11'd600, 12'd2, 1'b0);
    wait_done();
    check_frame("after abort", 11'd600, 2, 1, 5, 3);

    // reset mid-frame
    clear_mon();
    do_start(11'd700, 12'd40, 1'b0);
    for (int k = 0; k < 200 && got_b.size() < 7; k++) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset mem_en", mem_en, 0);
    check("midreset mem_addr", mem_addr, 0);
    check("midreset tx_data", tx_data, 0);
    check("midreset tx_valid", tx_valid, 0);
    check("midreset tx_last", tx_last, 0);
    clear_mon();
    do_start(11'd50, 12'd5, 1'b0);
    wait_done();
    check_frame("after reset", 11'd50, 5, 3, 8, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/eth_tx_frame_reader.md
# eth_tx_frame_reader

Reads an outgoing Ethernet frame from the 16-bit port of the dual-port frame buffer and streams it byte by byte to the MAC transmitter over a valid/ready interface. Software writes the frame into the buffer through the 64-bit port, then issues `start` with a base halfword address and a byte length. The block prefetches halfwords so the MAC can take one byte per cycle. It sits between the TX frame buffer and the MAC TX path, on the MAC-side clock.

## Interface
- `ADDR_W`, 11: halfword address width of the buffer's 16-bit port.
- `LEN_W`, 12: byte-length width.
- `clk`  in  1  block clock; also clocks the buffer's 16-bit port.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; accepted only in IDLE.
- `base_addr`  in  ADDR_W  first halfword address, sampled with `start`.
- `len`  in  LEN_W  frame length in bytes, sampled with `start`.
- `abort`  in  1  cancel the current frame.
- `busy`  out  1  high from the cycle after `start` is accepted until the frame completes or is aborted.
- `done`  out  1  one-cycle pulse at normal completion.
- `mem_en`  out  1  buffer read enable.
- `mem_addr`  out  ADDR_W  buffer halfword address.
- `mem_rdata`  in  16  buffer read data, valid the cycle after `mem_en`.
- `tx_data`  out  8  byte to the MAC.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_last`  out  1  marks the final byte of the frame; qualified by `tx_valid`.
- `tx_ready`  in  1  MAC accepts the byte.

## Operation
- **States:** IDLE, RUN, DONE.
  - IDLE to RUN: `start` high; latch `base_addr`, `len`.
  - IDLE to DONE: `start` high with `len`=0; no reads, no bytes.
  - RUN to DONE: the handshake of the byte carrying `tx_last`.
  - DONE to IDLE: always, after 1 cycle; `done`=1 in DONE.
- **Byte order:** each halfword is sent low byte `[7:0]` first, then `[15:8]`. This matches little-endian 64-bit writes.
- **Halfword count:** ceil(`len`/2). For odd `len`, the high byte of the last halfword is dropped and `tx_last` goes on its low byte.
- **Addressing:** `mem_addr` = `base_addr` + k mod 2^ADDR_W, where k is the halfword index. Wrap past the top of the buffer is legal.
- **Datapath:** a current-halfword register with a byte select, plus a one-entry prefetch register.
  - Issue a read when halfwords remain to fetch, no read is in flight, and the prefetch register is empty or being emptied this cycle.
  - At most one read is outstanding.
- **Streaming:** `tx_data`/`tx_last` are registered. While `tx_valid`=1 and `tx_ready`=0, `tx_valid`, `tx_data` and `tx_last` hold stable. `tx_valid` never depends combinationally on `tx_ready`.
- **Abort** (any state except IDLE):
  - next cycle: `tx_valid`=0, `mem_en`=0, `busy`=0, state IDLE, no `done`;
  - read data already in flight is discarded;
  - `abort` in IDLE is ignored;
  - `abort` together with `start` in IDLE: `start` wins.
- **Commands while active:** `start` in RUN or DONE is ignored, not queued. `start` in the cycle after DONE (IDLE) is accepted.
- **Reset (including mid-frame):** all outputs 0 (`busy`, `done`, `mem_en`, `mem_addr`, `tx_data`, `tx_valid`, `tx_last`); state IDLE; prefetch and in-flight data discarded.

## Timing
- `start` sampled at edge of cycle 0.
  - Cycle 1: `mem_en`=1, `mem_addr`=`base_addr`, `busy`=1.
  - Cycle 2: `mem_rdata` valid, captured.
  - Cycle 3: first `tx_valid`.
- **Throughput:** with `tx_ready` held high, one byte per cycle from cycle 3 with no bubbles.
  - Second read issued in cycle 3.
  - An N-byte frame ends its last handshake in cycle N+2.
  - `done` in cycle N+3.
  - Total `mem_en` cycles = ceil(N/2).
- **Backpressure:** no read issues while the prefetch register is full and the current halfword is not finishing. Reads resume so the stream is bubble-free once `tx_ready` returns.
- **`len`=0:** `done` in cycle 1; `busy` stays 0.

## Structure
- Package `eth_tx_pkg` holds:
  - the state enum `tx_rd_state_t` (IDLE, RUN, DONE);
  - default `ADDR_W`/`LEN_W` localparams shared with the buffer instantiation.
- Single module with no sub-modules; the halfword and prefetch registers are inline. Instantiated next to the TX frame buffer, driving its 16-bit port; the 64-bit port belongs to software.

## Test plan
- **Full-rate stream:** buffer halfwords 0x0100 at addr 5 and 0x0302 at addr 6; start `base_addr`=5, `len`=4, `tx_ready`=1. Expect bytes 00,01,02,03 in cycles 3..6, `tx_last` on 03, `done` in cycle 7, exactly 2 `mem_en` cycles.
- **Odd length and wrap:** `base_addr`=0x7FF, `len`=3, data 0xBBAA at 0x7FF and 0xDDCC at 0x000. Expect AA,BB,CC with `tx_last` on CC; DD never sent; `mem_addr` goes 0x7FF then 0x000.
- **Backpressure:** `len`=64, `tx_ready` toggling 1,0,0,1 repeatedly. Expect all 64 bytes in order, data stable while not ready, never more than 1 read outstanding, and exactly 32 reads.
- **Zero length and ignored start:** `len`=0 gives `done` in cycle 1 and no `tx_valid`. Then a second `start` pulsed mid-frame of a `len`=10 transfer is ignored: exactly 10 bytes and 1 `done`.
- **Abort:** `len`=100, assert `abort` after byte 20. Expect `tx_valid`=0 next cycle, no `done`, `busy`=0. A new `start` with `len`=2 then yields exactly 2 correct bytes with no stale prefetch data.
- **Reset:** `rst` mid-frame at byte 7. Expect all outputs 0 the next cycle; then a clean frame after reset release.
